// File: rtl/ct_spsram_256x84_ctrl.sv
// rtl/ct_spsram_256x84_ctrl.sv - two-port round-robin controller for a 256x84 single-port SRAM
// Clears the array after reset or on inv_req, then arbitrates one access per cycle.
module ct_spsram_256x84_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 84,
  parameter int HALF_WIDTH = 42
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_done,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  input  logic                  req0_wen,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [1:0]            req0_wmask,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  input  logic                  req1_wen,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [1:0]            req1_wmask,
  output logic                  rsp_vld,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    RST_WAIT,
    INIT,
    RUN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    rr_last_q, rr_last_d;
  logic                    inv_pend_q, inv_pend_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic                    rsp_id_q, rsp_id_d;
  logic                    inv_done_q, inv_done_d;
  logic [ADDR_WIDTH-1:0]   a_hold_q, a_hold_d;
  logic [DATA_WIDTH-1:0]   d_hold_q, d_hold_d;

  logic                    gnt0;
  logic                    gnt1;
  logic                    gnt_vld;
  logic                    gnt_id;
  logic                    sel_wen;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [1:0]              sel_wmask;

  // rr_last points at the previous tie winner; the other side wins the next tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == RUN && !inv_pend_q) begin
      if (req0_vld && req1_vld) begin
        gnt0 = rr_last_q;
        gnt1 = !rr_last_q;
      end else begin
        gnt0 = req0_vld;
        gnt1 = req1_vld;
      end
    end
  end

  assign gnt_vld   = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign sel_wen   = gnt1 ? req1_wen   : req0_wen;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  assign sel_wmask = gnt1 ? req1_wmask : req0_wmask;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_last_d  = rr_last_q;
    inv_pend_d = inv_pend_q;
    rsp_vld_d  = 1'b0;
    rsp_id_d   = rsp_id_q;
    inv_done_d = 1'b0;
    a_hold_d   = a_hold_q;
    d_hold_d   = d_hold_q;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = '1;
    sram_a     = a_hold_q;
    sram_d     = d_hold_q;

    case (state_q)
      RST_WAIT: begin
        state_d    = INIT;
        init_cnt_d = '0;
        inv_pend_d = 1'b0;
      end

      INIT: begin
        sram_cen   = 1'b0;
        sram_gwen  = 1'b0;
        sram_wen   = '0;
        sram_a     = init_cnt_q;
        sram_d     = '0;
        a_hold_d   = init_cnt_q;
        d_hold_d   = '0;
        inv_pend_d = 1'b0;
        if (inv_req) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == LAST_ADDR) begin
          state_d    = RUN;
          inv_done_d = 1'b1;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        end
      end

      RUN: begin
        if (gnt_vld) begin
          sram_cen = 1'b0;
          sram_a   = sel_addr;
          a_hold_d = sel_addr;
          if (sel_wen) begin
            sram_gwen = 1'b0;
            sram_wen  = {~{HALF_WIDTH{sel_wmask[1]}}, ~{HALF_WIDTH{sel_wmask[0]}}};
            sram_d    = sel_wdata;
            d_hold_d  = sel_wdata;
          end else begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = gnt_id;
          end
          if (req0_vld && req1_vld) begin
            rr_last_d = gnt_id;
          end
        end
        // A read granted alongside inv_req still completes; the sweep starts next cycle
        if (inv_req) begin
          inv_pend_d = 1'b1;
          state_d    = INIT;
        end
      end

      default: begin
        state_d = RST_WAIT;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= RST_WAIT;
      init_cnt_q <= '0;
      rr_last_q  <= 1'b1;
      inv_pend_q <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      inv_done_q <= 1'b0;
      a_hold_q   <= '0;
      d_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_last_q  <= rr_last_d;
      inv_pend_q <= inv_pend_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      inv_done_q <= inv_done_d;
      a_hold_q   <= a_hold_d;
      d_hold_q   <= d_hold_d;
    end
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_data = sram_q;
  assign inv_done = inv_done_q;

endmodule

// File: tb/tb_ct_spsram_256x84_ctrl.sv
// tb/tb_ct_spsram_256x84_ctrl.sv - self-checking bench for ct_spsram_256x84_ctrl
module tb_ct_spsram_256x84_ctrl;
  localparam int AW = 8;
  localparam int DW = 84;
  localparam int HW = 42;
  typedef logic [DW-1:0] w_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           inv_req = 1'b0;
  logic           inv_done;
  logic           req0_vld = 1'b0, req0_wen = 1'b0;
  logic [AW-1:0]  req0_addr = '0;
  w_t             req0_wdata = '0;
  logic [1:0]     req0_wmask = '0;
  logic           req1_vld = 1'b0, req1_wen = 1'b0;
  logic [AW-1:0]  req1_addr = '0;
  w_t             req1_wdata = '0;
  logic [1:0]     req1_wmask = '0;
  logic           req0_rdy, req1_rdy;
  logic           rsp_vld, rsp_id;
  w_t             rsp_data;
  logic           sram_cen, sram_gwen;
  w_t             sram_wen, sram_d;
  logic [AW-1:0]  sram_a;
  w_t             sram_q = '0;

  always #5 clk = ~clk;

  ct_spsram_256x84_ctrl dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .inv_req(inv_req), .inv_done(inv_done),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_wen(req0_wen), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_wen(req1_wen), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  // SRAM macro: bit-masked write, registered read
  w_t sram_mem [256];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  // Reference model: array contents plus phase / sweep position / tie priority
  w_t          ref_mem [256];
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_prio = 0;
  bit          m_rsp_v = 1'b0;
  bit          m_rsp_id = 1'b0;
  w_t          m_rsp_d = '0;
  bit          m_done = 1'b0;
  logic [AW-1:0] m_last_a = '0;
  w_t          m_last_d = '0;

  int n_err = 0;
  int n_chk = 0;
  int seen_done = 0;
  int obs_clr = 0;

  typedef struct {
    bit v0; bit w0; logic [AW-1:0] a0; w_t d0; logic [1:0] m0;
    bit v1; bit w1; logic [AW-1:0] a1; w_t d1; logic [1:0] m1;
    bit er0; bit er1; bit erv; bit eid; w_t erd;
  } vec_t;

  function automatic w_t rand84();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int g;
    logic w;
    logic [AW-1:0] ad;
    w_t wd;
    logic [1:0] wm;
    if (!rst_n) begin
      chk("rst_cen", w_t'(sram_cen), w_t'(1'b1));
      chk("rst_rdy0", w_t'(req0_rdy), '0);
      chk("rst_rdy1", w_t'(req1_rdy), '0);
      chk("rst_rsp_vld", w_t'(rsp_vld), '0);
      chk("rst_inv_done", w_t'(inv_done), '0);
      m_phase = 0; m_prio = 0; m_rsp_v = 1'b0; m_done = 1'b0; m_cnt = 0;
      return;
    end
    if (inv_done) seen_done++;
    if (!sram_cen && !sram_gwen && sram_wen == '0 && sram_d == '0) obs_clr++;
    chk("inv_done", w_t'(inv_done), w_t'(m_done));
    chk("rsp_vld", w_t'(rsp_vld), w_t'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_id", w_t'(rsp_id), w_t'(m_rsp_id));
      chk("rsp_data", rsp_data, m_rsp_d);
    end
    g = -1;
    if (m_phase == 2) begin
      if (req0_vld && req1_vld) g = m_prio;
      else if (req0_vld)        g = 0;
      else if (req1_vld)        g = 1;
    end
    chk("rdy0", w_t'(req0_rdy), w_t'(g == 0));
    chk("rdy1", w_t'(req1_rdy), w_t'(g == 1));
    if (g == 1) begin w = req1_wen; ad = req1_addr; wd = req1_wdata; wm = req1_wmask; end
    else        begin w = req0_wen; ad = req0_addr; wd = req0_wdata; wm = req0_wmask; end
    if (m_phase == 0) begin
      chk("wait_cen", w_t'(sram_cen), w_t'(1'b1));
    end else if (m_phase == 1) begin
      chk("sweep_cen", w_t'(sram_cen), '0);
      chk("sweep_gwen", w_t'(sram_gwen), '0);
      chk("sweep_wen", sram_wen, '0);
      chk("sweep_d", sram_d, '0);
      chk("sweep_a", w_t'(sram_a), w_t'(m_cnt));
    end else if (g < 0) begin
      chk("idle_cen", w_t'(sram_cen), w_t'(1'b1));
      chk("idle_gwen", w_t'(sram_gwen), w_t'(1'b1));
      chk("idle_wen", sram_wen, '1);
      chk("idle_a_hold", w_t'(sram_a), w_t'(m_last_a));
      chk("idle_d_hold", sram_d, m_last_d);
    end else begin
      chk("acc_cen", w_t'(sram_cen), '0);
      chk("acc_a", w_t'(sram_a), w_t'(ad));
      if (w) begin
        chk("wr_gwen", w_t'(sram_gwen), '0);
        chk("wr_wen", sram_wen, {{HW{!wm[1]}}, {HW{!wm[0]}}});
        chk("wr_d", sram_d, wd);
      end else begin
        chk("rd_gwen", w_t'(sram_gwen), w_t'(1'b1));
        chk("rd_wen", sram_wen, '1);
      end
    end
    m_done = 1'b0;
    m_rsp_v = 1'b0;
    case (m_phase)
      0: begin m_phase = 1; m_cnt = 0; end
      1: begin
        ref_mem[m_cnt] = '0;
        m_last_a = AW'(m_cnt);
        m_last_d = '0;
        if (inv_req) m_cnt = 0;
        else if (m_cnt == 255) begin m_phase = 2; m_done = 1'b1; m_cnt = 0; end
        else m_cnt++;
      end
      default: begin
        if (g >= 0) begin
          m_last_a = ad;
          if (w) begin
            if (wm[0]) ref_mem[ad][HW-1:0]  = wd[HW-1:0];
            if (wm[1]) ref_mem[ad][DW-1:HW] = wd[DW-1:HW];
            m_last_d = wd;
          end else begin
            m_rsp_v = 1'b1;
            m_rsp_id = (g == 1);
            m_rsp_d = ref_mem[ad];
          end
          if (req0_vld && req1_vld) m_prio = 1 - g;
        end
        if (inv_req) m_phase = 1;
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_vld = 1'b0; req1_vld = 1'b0; inv_req = 1'b0;
  endtask

  vec_t tbl [13];
  localparam w_t D1 = 84'hABCDEF0123456789ABCDE;
  localparam w_t LOW_ONES = {{HW{1'b0}}, {HW{1'b1}}};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = rand84();
      ref_mem[i] = rand84();
    end
    //                 v0   w0   a0     d0   m0     v1   w1   a1     d1   m1     r0   r1   rv   id   rd
    tbl[0]  = '{1'b1, 1'b1, 8'h12, D1,  2'b11, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[1]  = '{1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, D1};
    tbl[3]  = '{1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[4]  = '{1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, D1};
    tbl[5]  = '{1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b1, 1'b0, 1'b1, 1'b1, D1};
    tbl[6]  = '{1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b1, 1'b0, 8'h12, '0,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, D1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b1, 1'b1, 8'h34, '1,  2'b01, 1'b0, 1'b1, 1'b1, 1'b1, D1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b1, 1'b0, 8'h34, '0,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, '0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b1, LOW_ONES};
    tbl[10] = '{1'b1, 1'b1, 8'h34, '1,  2'b00, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[11] = '{1'b1, 1'b0, 8'h34, '0,  2'b00, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b0, 1'b0, 8'h00, '0,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0, LOW_ONES};

    // Reset held with both requesters asking; rdy must stay low through the sweep
    req0_vld = 1'b1; req1_vld = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    obs_clr = 0; seen_done = 0;
    for (int i = 0; i < 300 && m_phase != 2; i++) step();
    idle_inputs();
    repeat (3) step();
    chk("sweep_len", w_t'(obs_clr), w_t'(256));
    chk("done_pulses", w_t'(seen_done), w_t'(1));

    // Directed table: write/read-back, alternating ties, half-mask writes, empty mask
    for (int i = 0; i < 13; i++) begin
      req0_vld = tbl[i].v0; req0_wen = tbl[i].w0; req0_addr = tbl[i].a0;
      req0_wdata = tbl[i].d0; req0_wmask = tbl[i].m0;
      req1_vld = tbl[i].v1; req1_wen = tbl[i].w1; req1_addr = tbl[i].a1;
      req1_wdata = tbl[i].d1; req1_wmask = tbl[i].m1;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy0", i), w_t'(req0_rdy), w_t'(tbl[i].er0));
      chk($sformatf("tbl%0d_rdy1", i), w_t'(req1_rdy), w_t'(tbl[i].er1));
      chk($sformatf("tbl%0d_rsp_vld", i), w_t'(rsp_vld), w_t'(tbl[i].erv));
      if (tbl[i].erv) begin
        chk($sformatf("tbl%0d_rsp_id", i), w_t'(rsp_id), w_t'(tbl[i].eid));
        chk($sformatf("tbl%0d_rsp_data", i), rsp_data, tbl[i].erd);
      end
      model_check();
      @(posedge clk);
      #1;
    end
    idle_inputs();
    step();

    // Random traffic over a small address window, with occasional invalidates
    for (int i = 0; i < 800; i++) begin
      req0_vld = ($urandom_range(0, 3) != 0);
      req0_wen = ($urandom_range(0, 1) != 0);
      req0_addr = AW'($urandom_range(0, 15));
      req0_wdata = rand84();
      req0_wmask = 2'($urandom_range(0, 3));
      req1_vld = ($urandom_range(0, 3) != 0);
      req1_wen = ($urandom_range(0, 1) != 0);
      req1_addr = AW'($urandom_range(0, 15));
      req1_wdata = rand84();
      req1_wmask = 2'($urandom_range(0, 3));
      inv_req = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 600 && m_phase != 2; i++) step();
    step();

    // Invalidate in the same cycle as a read of freshly written data
    req0_vld = 1'b1; req0_wen = 1'b1; req0_addr = 8'd7; req0_wdata = 84'h5; req0_wmask = 2'b11;
    step();
    req0_vld = 1'b0;
    req1_vld = 1'b1; req1_wen = 1'b0; req1_addr = 8'd7; inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    req0_vld = 1'b1; req0_wen = 1'b0;
    obs_clr = 0; seen_done = 0;
    @(negedge clk);
    chk("inv_rd_vld", w_t'(rsp_vld), w_t'(1'b1));
    chk("inv_rd_id", w_t'(rsp_id), w_t'(1'b1));
    chk("inv_rd_data", rsp_data, 84'h5);
    chk("inv_rdy1_blocked", w_t'(req1_rdy), '0);
    model_check();
    @(posedge clk);
    #1;
    for (int i = 0; i < 400 && seen_done == 0; i++) step();
    idle_inputs();
    chk("inv_sweep_len", w_t'(obs_clr), w_t'(256));
    chk("inv_done_seen", w_t'(seen_done), w_t'(1));
    step();
    step();
    req1_vld = 1'b1; req1_wen = 1'b0; req1_addr = 8'd7;
    step();
    idle_inputs();
    @(negedge clk);
    chk("post_inv_vld", w_t'(rsp_vld), w_t'(1'b1));
    chk("post_inv_data", rsp_data, '0);
    model_check();
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a sweep
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    req0_vld = 1'b1; req1_vld = 1'b1;
    for (int i = 0; i < 300 && !(m_phase == 1 && m_cnt == 100); i++) step();
    chk("mid_sweep_cen", w_t'(sram_cen), '0);
    chk("mid_sweep_a", w_t'(sram_a), w_t'(100));
    rst_n = 1'b0;
    #1;
    chk("async_rst_cen", w_t'(sram_cen), w_t'(1'b1));
    chk("async_rst_rdy0", w_t'(req0_rdy), '0);
    chk("async_rst_rdy1", w_t'(req1_rdy), '0);
    step();
    step();
    rst_n = 1'b1;
    obs_clr = 0; seen_done = 0;
    for (int i = 0; i < 400 && seen_done == 0; i++) step();
    idle_inputs();
    chk("rst_sweep_len", w_t'(obs_clr), w_t'(256));
    chk("rst_done_seen", w_t'(seen_done), w_t'(1));
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ct_spsram_256x84_ctrl.md
Name: ct_spsram_256x84_ctrl

Overview:
- Controller and arbiter in front of one 256x84 single-port SRAM macro (CEN/GWEN/WEN active-low interface).
- Shares the array between two requesters (req0, req1) using round-robin arbitration, one access per cycle.
- Clears the whole array after reset and on demand (invalidate sweep).
- Returns read data with a fixed 1-cycle latency, tagged with the requester ID.

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 84, SRAM data width.
- HALF_WIDTH, 42, width of one write-mask half (DATA_WIDTH/2).

Ports:
- forever_cpuclk  in  1  single clock.
- cpurst_b  in  1  asynchronous active-low reset.
- inv_req  in  1  pulse: start a clear sweep.
- inv_done  out  1  one-cycle pulse when a sweep completes.
- reqN_vld  in  1  request valid (N=0,1).
- reqN_rdy  out  1  request granted this cycle.
- reqN_wen  in  1  1=write, 0=read.
- reqN_addr  in  8  address.
- reqN_wdata  in  84  write data.
- reqN_wmask  in  2  bit0=bits[41:0], bit1=bits[83:42]; 1=write that half.
- rsp_vld  out  1  read data valid.
- rsp_id  out  1  requester of the read.
- rsp_data  out  84  read data.
- sram_cen  out  1  chip enable, active low.
- sram_gwen  out  1  global write enable, active low.
- sram_wen  out  84  bit write enables, active low.
- sram_a  out  8  address.
- sram_d  out  84  write data.
- sram_q  in  84  read data; valid the cycle after a read access.

Behaviour:
- FSM states: RST_WAIT (reset value), INIT, RUN.
- RST_WAIT: sram_cen=1; moves to INIT on the first clock after reset release.
- INIT: every cycle drives cen=0, gwen=0, wen all 0, d=0, a=init_cnt; init_cnt increments.
  - After writing address 255: goto RUN, pulse inv_done, clear init_cnt to 0.
  - Both reqN_rdy=0 throughout INIT.
- RUN, arbitration is combinational from the vld inputs:
  - Exactly one valid: that requester is granted.
  - Both valid: grant the requester not pointed to by rr_last, then update rr_last to the winner.
  - rr_last resets to 1, so req0 wins the first tie.
  - reqN_rdy = grant; a transfer completes on vld&rdy at the clock edge.
- Granted read: cen=0, gwen=1, wen all 1, a=addr.
  - Next cycle: rsp_vld=1, rsp_id=N, rsp_data=sram_q.
  - Back-to-back reads give back-to-back responses.
- Granted write: cen=0, gwen=0.
  - wen[41:0]=~{42{wmask[0]}}, wen[83:42]=~{42{wmask[1]}}, d=wdata, a=addr.
  - wmask=00 still consumes the slot: gwen=0, no bits written, no response.
  - Writes never produce rsp_vld.
- No grant: cen=1. gwen=1, wen all 1, a and d hold their last driven values to avoid toggling.
- Invalidate:
  - inv_req in RUN sets inv_pend. inv_pend forces rdy=0 in the following cycle and the FSM enters INIT.
  - A read granted in the same cycle as inv_req still returns its response.
  - inv_req during INIT restarts init_cnt at 0; only one inv_done pulse follows.
- rsp_vld is registered and not backpressured; consumers must accept it.
- Reset mid-operation asserts asynchronously:
  - Reset values: state=RST_WAIT, init_cnt=0, rr_last=1, inv_pend=0, rsp_vld=0, rsp_id=0, inv_done=0.
  - sram_cen=1 and reqN_rdy=0 while cpurst_b is low.
  - The full sweep reruns after release.
- init_cnt is 8 bits and stops at 255 (no wrap into a second pass).

Test Plan:
- Reset release, no requests:
  - 256 consecutive cycles with cen=0, gwen=0, d=0, a=0..255.
  - inv_done pulses once, on the cycle after a=255 is written.
  - rdy stays 0 until RUN.
- After init, req0 writes addr 0x12 with data 0xABC..., wmask=11; next cycle req0 reads 0x12:
  - rsp_vld=1 one cycle after the read grant, rsp_id=0, rsp_data equals the written data.
- req0 and req1 both hold reads continuously:
  - Grants alternate 0,1,0,1 starting with req0.
  - rsp_id alternates in step, with no bubbles.
- Write with wmask=01 of all-ones to a cleared address, then read:
  - rsp_data[41:0] all ones, rsp_data[83:42]=0.
- Write 0x5 to addr 7, then assert inv_req while req1 reads addr 7 in the same cycle:
  - The read returns 0x5.
  - Next 256 cycles are the clear sweep with rdy=0, then inv_done.
  - A read of addr 7 afterwards returns 0.
- Assert cpurst_b low at init_cnt=100:
  - cen goes to 1 immediately.
  - After release, the sweep restarts at a=0 and runs the full 256 cycles.
